// File: rtl/vpack.sv
// vpack: packs scalars into VECTOR_SIZE-lane vectors; m_valid one cycle after the closing beat; stalls s_ready in HOLD.
// Optional VPACK_ZERO_FILL_EN clears the fill buffer on each transfer so unwritten lanes read zero.
module vpack #(
    parameter int VECTOR_SIZE = 16,
    parameter int INT_SIZE    = 16
) (
    input  logic                                 clock,
    input  logic                                 resetn,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [INT_SIZE-1:0]                  s_data,
    input  logic                                 s_last,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [VECTOR_SIZE-1:0][INT_SIZE-1:0] m_data,
    output logic [$clog2(VECTOR_SIZE):0]         m_count
);

    localparam int IW = $clog2(VECTOR_SIZE);
    localparam int CW = IW + 1;

    typedef enum logic {FILL, HOLD} state_t;

    state_t                              state_q, state_d;
    logic                                s_ready_q, s_ready_d;
    logic [IW-1:0]                       idx_q, idx_d;
    logic [CW-1:0]                       cnt_q, cnt_d;
    logic [VECTOR_SIZE-1:0][INT_SIZE-1:0] fill_q, fill_d;
    logic                                m_valid_q, m_valid_d;
    logic [VECTOR_SIZE-1:0][INT_SIZE-1:0] m_data_q, m_data_d;
    logic [CW-1:0]                       m_count_q, m_count_d;

    logic          accept;
    logic          closing;
    logic          slot_free;
    logic [CW-1:0] beat_cnt;

    assign accept    = s_valid && s_ready_q;
    assign closing   = (idx_q == IW'(VECTOR_SIZE - 1)) || s_last;
    assign slot_free = !m_valid_q || m_ready;
    assign beat_cnt  = {1'b0, idx_q} + CW'(1);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        fill_d    = fill_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_count_d = m_count_q;
        if (m_ready) begin
            m_valid_d = 1'b0;
        end
        case (state_q)
            FILL: begin
                if (accept) begin
                    // Closing lane is kept in the fill buffer too, so stale lanes always come from the previous vector.
                    fill_d[idx_q] = s_data;
                    if (closing) begin
                        if (slot_free) begin
                            m_data_d  = fill_d;
                            m_count_d = beat_cnt;
                            m_valid_d = 1'b1;
                            idx_d     = '0;
`ifdef VPACK_ZERO_FILL_EN
                            fill_d    = '0;
`endif
                        end else begin
                            cnt_d   = beat_cnt;
                            state_d = HOLD;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            HOLD: begin
                if (m_valid_q && m_ready) begin
                    m_data_d  = fill_q;
                    m_count_d = cnt_q;
                    m_valid_d = 1'b1;
                    idx_d     = '0;
                    state_d   = FILL;
`ifdef VPACK_ZERO_FILL_EN
                    fill_d    = '0;
`endif
                end
            end
            default: state_d = FILL;
        endcase
        s_ready_d = (state_d == FILL);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= FILL;
            s_ready_q <= 1'b0;
            idx_q     <= '0;
            cnt_q     <= '0;
            fill_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_count_q <= '0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            fill_q    <= fill_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_count_q <= m_count_d;
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_count = m_count_q;

endmodule

// File: tb/tb_vpack.sv
// Bench for vpack: directed scenarios plus a randomized handshake run checked against a lane-array reference model.
module tb_vpack;

    localparam int VS = 16;
    localparam int W  = 16;
    localparam int FW = VS * W;

    logic                   clock;
    logic                   resetn;
    logic                   s_valid;
    logic                   s_ready;
    logic [W-1:0]           s_data;
    logic                   s_last;
    logic                   m_valid;
    logic                   m_ready;
    logic [VS-1:0][W-1:0]   m_data;
    logic [4:0]             m_count;
    logic [FW-1:0]          flat;

    int total = 0;
    int bad   = 0;

    vpack #(.VECTOR_SIZE(VS), .INT_SIZE(W)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_count (m_count)
    );

    assign flat = m_data;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a lane array written in order, snapshotted into a queue when a vector closes.
    logic [W-1:0]  cur [VS];
    int            n_lane = 0;
    logic [FW-1:0] exp_dat_q [$];
    int            exp_cnt_q [$];
    int            nbeats = 0;
    int            nvec_in = 0;
    int            nvec_out = 0;

    function automatic logic [FW-1:0] pack_cur();
        logic [FW-1:0] v;
        for (int k = 0; k < VS; k++) v[k*W +: W] = cur[k];
        return v;
    endfunction

    initial for (int k = 0; k < VS; k++) cur[k] = '0;

    always @(posedge clock) begin
        if (!resetn) begin
            for (int k = 0; k < VS; k++) cur[k] = '0;
            n_lane = 0;
            exp_dat_q.delete();
            exp_cnt_q.delete();
        end else if (s_valid && s_ready) begin
            nbeats++;
            cur[n_lane] = s_data;
            n_lane++;
            if (n_lane == VS || s_last) begin
                exp_dat_q.push_back(pack_cur());
                exp_cnt_q.push_back(n_lane);
                nvec_in++;
                n_lane = 0;
`ifdef VPACK_ZERO_FILL_EN
                for (int k = 0; k < VS; k++) cur[k] = '0;
`endif
            end
        end
    end

    logic          hold_prev = 1'b0;
    logic [FW-1:0] prev_dat;
    logic [4:0]    prev_cnt;

    always @(negedge clock) begin
        if (!resetn) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("stall_valid", FW'(m_valid), FW'(1));
                chk("stall_data", flat, prev_dat);
                chk("stall_count", FW'(m_count), FW'(prev_cnt));
            end
            if (m_valid && m_ready) begin
                nvec_out++;
                if (exp_dat_q.size() == 0) begin
                    chk("sb_unexpected_vector", FW'(1), FW'(0));
                end else begin
                    chk("sb_data", flat, exp_dat_q.pop_front());
                    chk("sb_count", FW'(m_count), FW'(exp_cnt_q.pop_front()));
                end
            end
            hold_prev = m_valid && !m_ready;
            prev_dat  = flat;
            prev_cnt  = m_count;
        end
    end

    task automatic beat(input logic [W-1:0] d, input logic l, output int w);
        logic acc;
        acc = 1'b0;
        w = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            acc = s_ready;
            @(posedge clock);
            #1;
            if (acc) break;
            w++;
        end
        if (!acc) chk("beat_timeout", FW'(0), FW'(1));
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic idle(input int c);
        for (int k = 0; k < c; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        int            w;
        int            wsum;
        int            v0;
        int            start;
        logic [FW-1:0] e;

        resetn  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        idle(2);
        @(negedge clock);
        chk("rst_s_ready", FW'(s_ready), FW'(0));
        chk("rst_m_valid", FW'(m_valid), FW'(0));
        chk("rst_m_count", FW'(m_count), FW'(0));
        chk("rst_m_data", flat, FW'(0));
        @(posedge clock);
        #1;
        resetn = 1'b1;
        @(negedge clock);
        chk("rel_s_ready_low", FW'(s_ready), FW'(0));
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("rel_s_ready_high", FW'(s_ready), FW'(1));
        @(posedge clock);
        #1;

        // Full vector, no backpressure
        m_ready = 1'b1;
        wsum = 0;
        for (int i = 0; i < VS; i++) begin
            beat(W'(i + 1), 1'b0, w);
            wsum += w;
        end
        chk("full_no_wait", FW'(wsum), FW'(0));
        @(negedge clock);
        for (int k = 0; k < VS; k++) e[k*W +: W] = W'(k + 1);
        chk("full_valid", FW'(m_valid), FW'(1));
        chk("full_data", flat, e);
        chk("full_count", FW'(m_count), FW'(VS));
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("full_valid_drop", FW'(m_valid), FW'(0));
        @(posedge clock);
        #1;

        // Partial vector after a full vector of 7s
        for (int i = 0; i < VS; i++) beat(W'(7), 1'b0, w);
        beat(W'(4), 1'b0, w);
        beat(W'(6), 1'b1, w);
        @(negedge clock);
        for (int k = 0; k < VS; k++) begin
`ifdef VPACK_ZERO_FILL_EN
            e[k*W +: W] = W'(0);
`else
            e[k*W +: W] = W'(7);
`endif
        end
        e[0 +: W] = W'(4);
        e[W +: W] = W'(6);
        chk("partial_data", flat, e);
        chk("partial_count", FW'(m_count), FW'(2));
        @(posedge clock);
        #1;
        idle(2);

        // Backpressure: two vectors while m_ready is low
        m_ready = 1'b0;
        wsum = 0;
        for (int i = 0; i < 2 * VS; i++) begin
            beat(W'(100 + i), 1'b0, w);
            wsum += w;
        end
        chk("bp_no_wait", FW'(wsum), FW'(0));
        s_valid = 1'b1;
        s_data  = W'(200);
        s_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("bp_s_ready_low", FW'(s_ready), FW'(0));
            chk("bp_first_lane0", FW'(m_data[0]), FW'(100));
            chk("bp_first_count", FW'(m_count), FW'(VS));
            @(posedge clock);
            #1;
        end
        m_ready = 1'b1;
        @(negedge clock);
        chk("bp_release_s_ready", FW'(s_ready), FW'(0));
        chk("bp_release_lane0", FW'(m_data[0]), FW'(100));
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("bp_second_valid", FW'(m_valid), FW'(1));
        chk("bp_second_lane0", FW'(m_data[0]), FW'(100 + VS));
        chk("bp_second_lane15", FW'(m_data[VS-1]), FW'(100 + 2 * VS - 1));
        chk("bp_second_count", FW'(m_count), FW'(VS));
        chk("bp_s_ready_back", FW'(s_ready), FW'(1));
        @(posedge clock);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clock);
        chk("bp_beat33_lane0", FW'(m_data[0]), FW'(200));
        chk("bp_beat33_count", FW'(m_count), FW'(1));
        @(posedge clock);
        #1;

        // Single-lane vector
        beat(W'(16'hBEEF), 1'b1, w);
        @(negedge clock);
        chk("single_lane0", FW'(m_data[0]), FW'(16'hBEEF));
        chk("single_count", FW'(m_count), FW'(1));
        @(posedge clock);
        #1;
        idle(2);

        // Reset mid-operation
        for (int i = 0; i < 5; i++) beat(W'(9), 1'b0, w);
        resetn = 1'b0;
        @(negedge clock);
        chk("mid_rst_s_ready", FW'(s_ready), FW'(0));
        chk("mid_rst_m_valid", FW'(m_valid), FW'(0));
        chk("mid_rst_m_count", FW'(m_count), FW'(0));
        chk("mid_rst_m_data", flat, FW'(0));
        @(posedge clock);
        #1;
        resetn = 1'b1;
        v0 = nvec_out;
        for (int i = 0; i < VS; i++) beat(W'(2), 1'b0, w);
        @(negedge clock);
        for (int k = 0; k < VS; k++) e[k*W +: W] = W'(2);
        chk("mid_rst_data", flat, e);
        chk("mid_rst_count", FW'(m_count), FW'(VS));
        @(posedge clock);
        #1;
        idle(3);
        chk("mid_rst_one_vector", FW'(nvec_out - v0), FW'(1));

        // Random handshake
        start = nbeats;
        for (int c = 0; c < 60000 && nbeats < start + 10000; c++) begin
            s_valid = ($urandom % 4) != 0;
            s_data  = W'($urandom);
            s_last  = ($urandom % 8) == 0;
            m_ready = ($urandom % 4) != 0;
            @(posedge clock);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        chk("rand_beat_budget", FW'(nbeats >= start + 10000), FW'(1));
        idle(40);
        chk("rand_sb_drained", FW'(exp_dat_q.size()), FW'(0));
        chk("rand_vec_balance", FW'(nvec_out), FW'(nvec_in));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
